// File: rtl/hid2ps2_pkg.sv
// Shared types and byte constants for the HID boot-report to PS/2 Set-2 streamer.
package hid2ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOOKUP,
    EMIT_E0,
    EMIT_F0,
    EMIT_CODE
  } state_t;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] HID_ROLLOVER = 8'h01;
  localparam logic [7:0] HID_MOD_BASE = 8'hE0;

endpackage

// File: rtl/hid2ps2_stream_if.sv
// Report-in / PS/2-byte-out handshake bundle; slave is the converter, master the surroundings.
interface hid2ps2_stream_if #(
  parameter int NUM_KEYS = 6
) ();
  logic                  rpt_valid;
  logic                  rpt_ready;
  logic [7:0]            rpt_mod;
  logic [8*NUM_KEYS-1:0] rpt_keys;
  logic                  ps2_valid;
  logic                  ps2_ready;
  logic [7:0]            ps2_data;
  logic                  busy;

  modport slave  (input  rpt_valid, rpt_mod, rpt_keys, ps2_ready,
                  output rpt_ready, ps2_valid, ps2_data, busy);
  modport master (output rpt_valid, rpt_mod, rpt_keys, ps2_ready,
                  input  rpt_ready, ps2_valid, ps2_data, busy);
endinterface

// File: rtl/hid2ps2_lut.sv
// Registered USB usage -> PS/2 Set-2 ROM. bit8 = needs E0 prefix, 9'h000 = no mapping.
module hid2ps2_lut (
  input  logic       clk,
  input  logic [7:0] usb,
  output logic [8:0] ps2
);

  function automatic logic [8:0] rom(input logic [7:0] u);
    case (u)
      8'h04: rom = 9'h01C; 8'h05: rom = 9'h032; 8'h06: rom = 9'h021; 8'h07: rom = 9'h023;
      8'h08: rom = 9'h024; 8'h09: rom = 9'h02B; 8'h0A: rom = 9'h034; 8'h0B: rom = 9'h033;
      8'h0C: rom = 9'h043; 8'h0D: rom = 9'h03B; 8'h0E: rom = 9'h042; 8'h0F: rom = 9'h04B;
      8'h10: rom = 9'h03A; 8'h11: rom = 9'h031; 8'h12: rom = 9'h044; 8'h13: rom = 9'h04D;
      8'h14: rom = 9'h015; 8'h15: rom = 9'h02D; 8'h16: rom = 9'h01B; 8'h17: rom = 9'h02C;
      8'h18: rom = 9'h03C; 8'h19: rom = 9'h02A; 8'h1A: rom = 9'h01D; 8'h1B: rom = 9'h022;
      8'h1C: rom = 9'h035; 8'h1D: rom = 9'h01A; 8'h1E: rom = 9'h016; 8'h1F: rom = 9'h01E;
      8'h20: rom = 9'h026; 8'h21: rom = 9'h025; 8'h22: rom = 9'h02E; 8'h23: rom = 9'h036;
      8'h24: rom = 9'h03D; 8'h25: rom = 9'h03E; 8'h26: rom = 9'h046; 8'h27: rom = 9'h045;
      8'h28: rom = 9'h05A; 8'h29: rom = 9'h076; 8'h2A: rom = 9'h066; 8'h2B: rom = 9'h00D;
      8'h2C: rom = 9'h029; 8'h2D: rom = 9'h04E; 8'h2E: rom = 9'h055; 8'h2F: rom = 9'h054;
      8'h30: rom = 9'h05B; 8'h31: rom = 9'h05D; 8'h32: rom = 9'h05D; 8'h33: rom = 9'h04C;
      8'h34: rom = 9'h052; 8'h35: rom = 9'h00E; 8'h36: rom = 9'h041; 8'h37: rom = 9'h049;
      8'h38: rom = 9'h04A; 8'h39: rom = 9'h058; 8'h3A: rom = 9'h005; 8'h3B: rom = 9'h006;
      8'h3C: rom = 9'h004; 8'h3D: rom = 9'h00C; 8'h3E: rom = 9'h003; 8'h3F: rom = 9'h00B;
      8'h40: rom = 9'h083; 8'h41: rom = 9'h00A; 8'h42: rom = 9'h001; 8'h43: rom = 9'h009;
      8'h44: rom = 9'h078; 8'h45: rom = 9'h007; 8'h46: rom = 9'h17C; 8'h47: rom = 9'h07E;
      8'h49: rom = 9'h170; 8'h4A: rom = 9'h16C; 8'h4B: rom = 9'h17D; 8'h4C: rom = 9'h171;
      8'h4D: rom = 9'h169; 8'h4E: rom = 9'h17A; 8'h4F: rom = 9'h174; 8'h50: rom = 9'h16B;
      8'h51: rom = 9'h172; 8'h52: rom = 9'h175; 8'h53: rom = 9'h077; 8'h54: rom = 9'h14A;
      8'h55: rom = 9'h07C; 8'h56: rom = 9'h07B; 8'h57: rom = 9'h079; 8'h58: rom = 9'h15A;
      8'h59: rom = 9'h069; 8'h5A: rom = 9'h072; 8'h5B: rom = 9'h07A; 8'h5C: rom = 9'h06B;
      8'h5D: rom = 9'h073; 8'h5E: rom = 9'h074; 8'h5F: rom = 9'h06C; 8'h60: rom = 9'h075;
      8'h61: rom = 9'h07D; 8'h62: rom = 9'h070; 8'h63: rom = 9'h071; 8'h64: rom = 9'h061;
      8'h65: rom = 9'h12F;
      8'hE0: rom = 9'h014; 8'hE1: rom = 9'h012; 8'hE2: rom = 9'h011; 8'hE3: rom = 9'h11F;
      8'hE4: rom = 9'h114; 8'hE5: rom = 9'h059; 8'hE6: rom = 9'h111; 8'hE7: rom = 9'h127;
      default: rom = 9'h000; // Pause (48) and everything else: no single-code mapping
    endcase
  endfunction

  always_ff @(posedge clk) ps2 <= rom(usb);

endmodule

// File: rtl/hid2ps2_stream.sv
// Diffs successive HID boot reports and streams the resulting Set-2 make/break bytes.
module hid2ps2_stream
  import hid2ps2_pkg::*;
#(
  parameter int NUM_KEYS    = 6,
  parameter int BREAK_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  hid2ps2_stream_if.slave  bus
);

  localparam int   NIDX = 8 + NUM_KEYS;
  localparam int   IW   = $clog2(NIDX);
  localparam logic BF   = (BREAK_FIRST != 0);

  state_t                     state, state_d;
  logic                       brk;
  logic [IW-1:0]              idx, slot;
  logic [7:0]                 cur_mod, prev_mod;
  logic [NUM_KEYS-1:0][7:0]   cur_keys, prev_keys;
  logic [NUM_KEYS-1:0]        brk_ev, mk_ev;
  logic [NIDX-1:0]            ev_vec;
  logic                       ev, adv, accept, rollover, last, second;
  logic [7:0]                 usb;
  logic [8:0]                 code;

  // A slot counts only if its usage is absent from the other report and not repeated earlier in its own.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_slot
    logic b_ev, m_ev;
    always_comb begin
      b_ev = (prev_keys[k] != 8'h00);
      m_ev = (cur_keys[k] != 8'h00);
      for (int j = 0; j < NUM_KEYS; j++) begin
        if (cur_keys[j] == prev_keys[k]) b_ev = 1'b0;
        if (prev_keys[j] == cur_keys[k]) m_ev = 1'b0;
        if (j < k && prev_keys[j] == prev_keys[k]) b_ev = 1'b0;
        if (j < k && cur_keys[j] == cur_keys[k]) m_ev = 1'b0;
      end
    end
    assign brk_ev[k] = b_ev;
    assign mk_ev[k]  = m_ev;
  end

  always_comb begin
    rollover = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (bus.rpt_keys[8*k +: 8] == HID_ROLLOVER) rollover = 1'b1;
  end

  assign ev_vec = brk ? {brk_ev, prev_mod & ~cur_mod} : {mk_ev, cur_mod & ~prev_mod};
  assign ev     = ev_vec[idx];
  assign last   = (idx == IW'(NIDX - 1));
  assign second = (brk != BF);
  assign slot   = idx - IW'(8);
  assign usb    = (idx < IW'(8)) ? (HID_MOD_BASE | {5'b0, idx[2:0]})
                                 : (brk ? prev_keys[slot] : cur_keys[slot]);

  hid2ps2_lut u_lut (.clk(clk), .usb(usb), .ps2(code));

  always_comb begin
    state_d = state;
    adv     = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE:      if (bus.rpt_valid) begin
                   accept = 1'b1;
                   if (!rollover) state_d = SCAN;
                 end
      SCAN:      if (ev) state_d = LOOKUP;
                 else    adv     = 1'b1;
      LOOKUP:    if (code == 9'h000) adv     = 1'b1;
                 else if (code[8])   state_d = EMIT_E0;
                 else if (brk)       state_d = EMIT_F0;
                 else                state_d = EMIT_CODE;
      EMIT_E0:   if (bus.ps2_ready) state_d = brk ? EMIT_F0 : EMIT_CODE;
      EMIT_F0:   if (bus.ps2_ready) state_d = EMIT_CODE;
      EMIT_CODE: if (bus.ps2_ready) adv = 1'b1;
      default:   state_d = IDLE;
    endcase
    if (adv) state_d = (last && second) ? IDLE : SCAN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      brk       <= BF;
      idx       <= '0;
      cur_mod   <= '0;
      cur_keys  <= '0;
      prev_mod  <= '0;
      prev_keys <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        cur_mod  <= bus.rpt_mod;
        cur_keys <= bus.rpt_keys;
        idx      <= '0;
        brk      <= BF;
      end
      if (adv) begin
        if (last) begin
          idx <= '0;
          if (second) begin
            prev_mod  <= cur_mod;
            prev_keys <= cur_keys;
          end else begin
            brk <= ~brk;
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  always_comb begin
    case (state)
      EMIT_E0:   bus.ps2_data = PS2_EXT;
      EMIT_F0:   bus.ps2_data = PS2_BRK;
      EMIT_CODE: bus.ps2_data = code[7:0];
      default:   bus.ps2_data = 8'h00;
    endcase
  end

  // Outputs depend on state only, so ps2_ready never reaches ps2_valid combinationally.
  assign bus.ps2_valid = (state == EMIT_E0) || (state == EMIT_F0) || (state == EMIT_CODE);
  assign bus.rpt_ready = (state == IDLE) && reset_n;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_hid2ps2_stream.sv
// Report-diff streamer bench: queue-based reference of expected PS/2 bytes, random and directed reports.
module tb_hid2ps2_stream;
  localparam int NK = 6;
  localparam int BF = 1;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hid2ps2_stream_if #(.NUM_KEYS(NK)) bus ();
  hid2ps2_stream #(.NUM_KEYS(NK), .BREAK_FIRST(BF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  bq_t exp_q;
  logic [7:0]      pm = 8'h00;
  logic [8*NK-1:0] pk = '0;
  int rdy_mode = 0;
  logic [7:0] pool [12] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h16, 8'h2C,
                            8'h29, 8'h4F, 8'h50, 8'h52, 8'h48, 8'h4A};

  // Set-2 codes for the usages the stimulus draws from.
  function automatic logic [8:0] lut9(input logic [7:0] u);
    case (u)
      8'h04: return 9'h01C; 8'h05: return 9'h032; 8'h06: return 9'h021;
      8'h07: return 9'h023; 8'h16: return 9'h01B; 8'h2C: return 9'h029;
      8'h29: return 9'h076; 8'h4F: return 9'h174; 8'h50: return 9'h16B;
      8'h52: return 9'h175; 8'h4A: return 9'h16C;
      8'hE0: return 9'h014; 8'hE1: return 9'h012; 8'hE2: return 9'h011;
      8'hE3: return 9'h11F; 8'hE4: return 9'h114; 8'hE5: return 9'h059;
      8'hE6: return 9'h111; 8'hE7: return 9'h127;
      default: return 9'h000;
    endcase
  endfunction

  function automatic bit has(input logic [8*NK-1:0] ks, input logic [7:0] u);
    for (int k = 0; k < NK; k++) if (ks[8*k +: 8] == u) return 1'b1;
    return 1'b0;
  endfunction

  // Bytes a report transition must produce: released usages, then pressed ones, in report order.
  function automatic bq_t model(input logic [7:0] om, input logic [8*NK-1:0] ok,
                                input logic [7:0] nm, input logic [8*NK-1:0] nk);
    bq_t q;
    logic [255:0] seen;
    logic [7:0] fm, tm, u;
    logic [8*NK-1:0] fk, tk;
    logic [8:0] c;
    bit b;
    q = {};
    if (has(nk, 8'h01)) return q;
    for (int ph = 0; ph < 2; ph++) begin
      b = (ph == 0) ? (BF != 0) : (BF == 0);
      fm = b ? om : nm;  tm = b ? nm : om;
      fk = b ? ok : nk;  tk = b ? nk : ok;
      seen = '0;
      for (int i = 0; i < 8 + NK; i++) begin
        if (i < 8) begin
          if (!(fm[i] && !tm[i])) continue;
          u = 8'hE0 + 8'(i);
        end else begin
          u = fk[8*(i-8) +: 8];
          if (u == 8'h00 || seen[u]) continue;
          seen[u] = 1'b1;
          if (has(tk, u)) continue;
        end
        c = lut9(u);
        if (c == 9'h000) continue;
        if (c[8]) q.push_back(8'hE0);
        if (b) q.push_back(8'hF0);
        q.push_back(c[7:0]);
      end
    end
    return q;
  endfunction

  function automatic logic [8*NK-1:0] mk(input logic [7:0] k0, input logic [7:0] k1);
    logic [8*NK-1:0] v;
    v = '0;
    v[7:0]  = k0;
    v[15:8] = k1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    bus.ps2_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.ps2_ready = 1'b1;
        1:       bus.ps2_ready = 1'($urandom_range(0, 1));
        default: bus.ps2_ready = 1'b0;
      endcase
    end
  end

  // Every transferred byte is checked against the queue; a stalled byte must hold still.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", 32'(bus.ps2_valid), 32'd1);
        chk("stall_data", 32'(bus.ps2_data), 32'(hold_d));
      end
      if (bus.ps2_valid && bus.ps2_ready) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL extra_byte: got %h want no byte", bus.ps2_data);
        end else begin
          chk("ps2_byte", 32'(bus.ps2_data), 32'(exp_q.pop_front()));
        end
      end
      hold_v <= bus.ps2_valid && !bus.ps2_ready;
      hold_d <= bus.ps2_data;
    end
  end

  task automatic send(input logic [7:0] m, input logic [8*NK-1:0] k);
    bq_t q;
    int n;
    @(posedge clk); #1;
    bus.rpt_valid = 1'b1; bus.rpt_mod = m; bus.rpt_keys = k;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rpt_ready && n < 5000);
    if (!bus.rpt_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: rpt_ready got 0 want 1 within 5000 cycles");
    end else begin
      q = model(pm, pk, m, k);
      foreach (q[i]) exp_q.push_back(q[i]);
      if (!has(k, 8'h01)) begin pm = m; pk = k; end
    end
    @(posedge clk); #1;
    bus.rpt_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin @(negedge clk); n++; end
    chk("drain_in_time", 32'(n < 5000), 32'd1);
  endtask

  // Pin the model against hand-derived bytes (lit, MSB first), then run the report.
  task automatic pin(input logic [7:0] m, input logic [8*NK-1:0] k, input int n, input logic [63:0] lit);
    bq_t q;
    q = model(pm, pk, m, k);
    chk("model_len", 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++)
      chk("model_byte", 32'(q[i]), 32'(lit[8*(n-1-i) +: 8]));
  endtask

  task automatic do_rpt(input logic [7:0] m, input logic [8*NK-1:0] k, input int n, input logic [63:0] lit);
    pin(m, k, n, lit);
    send(m, k);
    wait_idle();
  endtask

  initial begin
    int n;
    logic [7:0] m;
    logic [8*NK-1:0] k;
    int r;
    bus.rpt_valid = 1'b0; bus.rpt_mod = 8'h00; bus.rpt_keys = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rpt_ready", 32'(bus.rpt_ready), 32'd0);
    chk("rst_ps2_valid", 32'(bus.ps2_valid), 32'd0);
    chk("rst_ps2_data", 32'(bus.ps2_data), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    do_rpt(8'h00, mk(8'h04, 8'h00), 1, 64'h1C);
    do_rpt(8'h00, '0, 2, 64'hF01C);
    do_rpt(8'h00, mk(8'h4F, 8'h00), 2, 64'hE074);

    // Release Right Arrow while the sink stalls on the E0 prefix.
    pin(8'h00, '0, 3, 64'hE0F074);
    rdy_mode = 2;
    send(8'h00, '0);
    n = 0;
    while (!bus.ps2_valid && n < 50) begin @(negedge clk); n++; end
    repeat (10) begin
      @(negedge clk);
      chk("stall_e0_valid", 32'(bus.ps2_valid), 32'd1);
      chk("stall_e0_data", 32'(bus.ps2_data), 32'hE0);
    end
    rdy_mode = 0;
    wait_idle();

    do_rpt(8'h00, mk(8'h04, 8'h00), 1, 64'h1C);
    do_rpt(8'h02, mk(8'h04, 8'h05), 2, 64'h1232);
    do_rpt(8'h00, '0, 6, 64'hF012F01CF032);

    // Rollover report is swallowed and leaves the previous report in place.
    do_rpt(8'h00, mk(8'h05, 8'h00), 1, 64'h32);
    pin(8'h00, mk(8'h04, 8'h01), 0, 64'h0);
    send(8'h00, mk(8'h04, 8'h01));
    @(negedge clk);
    chk("rollover_ready", 32'(bus.rpt_ready), 32'd1);
    chk("rollover_busy", 32'(bus.busy), 32'd0);
    do_rpt(8'h00, '0, 2, 64'hF032);

    // Best case: LCtrl release is event index 0 of the break phase.
    do_rpt(8'h01, '0, 1, 64'h14);
    pin(8'h00, '0, 2, 64'hF014);
    send(8'h00, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ps2_valid && n < 50);
    chk("first_byte_latency", 32'(n), 32'd3);
    wait_idle();

    do_rpt(8'h00, mk(8'h48, 8'h00), 0, 64'h0);
    do_rpt(8'h00, mk(8'h04, 8'h00), 1, 64'h1C);
    do_rpt(8'h00, '0, 2, 64'hF01C);

    // Reset while F0 is on the bus: pending bytes vanish and prev is forgotten.
    do_rpt(8'h00, mk(8'h04, 8'h00), 1, 64'h1C);
    pin(8'h00, mk(8'h05, 8'h00), 3, 64'hF01C32);
    rdy_mode = 2;
    send(8'h00, mk(8'h05, 8'h00));
    n = 0;
    while (!(bus.ps2_valid && bus.ps2_data == 8'hF0) && n < 50) begin @(negedge clk); n++; end
    chk("pre_reset_f0", 32'(bus.ps2_data), 32'hF0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    pm = 8'h00; pk = '0;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_reset_valid", 32'(bus.ps2_valid), 32'd0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    do_rpt(8'h00, mk(8'h05, 8'h00), 1, 64'h32);

    rdy_mode = 1;
    repeat (150) begin
      m = 8'($urandom);
      k = '0;
      for (int s = 0; s < NK; s++) begin
        r = int'($urandom_range(0, 39));
        if (r == 39)     k[8*s +: 8] = 8'h01;
        else if (r >= 12) k[8*s +: 8] = pool[$urandom_range(0, 11)];
      end
      send(m, k);
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
